// File: rtl/key_conditioner.sv
// key_conditioner: per-channel push-button front end.
// Each channel synchronises its raw pin, normalises polarity, debounces with a
// stable-cycle counter, emits one-cycle press/release events and, where
// enabled, an auto-repeat pulse train while the key stays held.
// The release event output is named "released" because "release" is a
// reserved word in SystemVerilog.
module key_conditioner #(
    parameter int                 N_KEYS          = 4,
    parameter bit                 ACTIVE_LOW      = 1'b1,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter logic [N_KEYS-1:0]  REPEAT_EN       = {N_KEYS{1'b0}},
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] released,
    output logic [N_KEYS-1:0] pulse
);

    // Reject parameter sets that would make the counters or the chain meaningless
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("key_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("key_conditioner: REPEAT_PERIOD must be >= 1");
    end

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // Terminal counts: the event fires on the edge where the count sits one below the target
    localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0]       DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]       PER_LAST  = RPT_W'(REPEAT_PERIOD - 1);
    // Idle pin level, so a reset chain never looks like a press
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   pressed_now;
        logic [DB_W-1:0]        db_cnt;
        logic                   held_q;
        logic                   press_q;
        logic                   release_q;
        logic                   db_flip;

        // Shift the raw asynchronous pin through the synchroniser chain
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                sync_q <= SYNC_IDLE;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], key_in[i]};
            end
        end

        // 1 = pressed, whatever the board polarity
        assign pressed_now = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
        // The accepted level flips when the disagreement has lasted long enough
        assign db_flip     = (pressed_now != held_q) && (db_cnt == DB_LAST);

        // Debounce: count consecutive disagreeing cycles, toggle held and emit edge events
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                db_cnt    <= '0;
                held_q    <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= db_flip & ~held_q;
                release_q <= db_flip & held_q;
                if (pressed_now == held_q) begin
                    db_cnt <= '0;
                end else if (db_flip) begin
                    held_q <= ~held_q;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign held[i]     = held_q;
        assign press[i]    = press_q;
        assign released[i] = release_q;

        if (REPEAT_EN[i]) begin : g_rpt
            rpt_state_t       rpt_state;
            rpt_state_t       rpt_next;
            logic [RPT_W-1:0] rpt_cnt;
            logic [RPT_W-1:0] rpt_cnt_next;
            logic             rpt_tick;
            logic             pulse_q;

            // Repeat state, counter and the merged press/repeat pulse register
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    rpt_state <= RPT_IDLE;
                    rpt_cnt   <= '0;
                    pulse_q   <= 1'b0;
                end else begin
                    rpt_state <= rpt_next;
                    rpt_cnt   <= rpt_cnt_next;
                    pulse_q   <= (db_flip & ~held_q) | rpt_tick;
                end
            end

            // Repeat sequencing: wait REPEAT_DELAY after the press, then tick every
            // REPEAT_PERIOD; the counter reloads on each tick so it never wraps
            always_comb begin
                rpt_next     = rpt_state;
                rpt_cnt_next = rpt_cnt;
                rpt_tick     = 1'b0;
                if (db_flip && !held_q) begin
                    rpt_next     = RPT_DELAY;
                    rpt_cnt_next = '0;
                end else if (db_flip && held_q) begin
                    rpt_next     = RPT_IDLE;
                    rpt_cnt_next = '0;
                end else begin
                    case (rpt_state)
                        RPT_DELAY: begin
                            if (rpt_cnt == DLY_LAST) begin
                                rpt_tick     = 1'b1;
                                rpt_next     = RPT_PERIOD;
                                rpt_cnt_next = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt + RPT_W'(1);
                            end
                        end
                        RPT_PERIOD: begin
                            if (rpt_cnt == PER_LAST) begin
                                rpt_tick     = 1'b1;
                                rpt_cnt_next = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt + RPT_W'(1);
                            end
                        end
                        default: begin
                            rpt_next     = RPT_IDLE;
                            rpt_cnt_next = '0;
                        end
                    endcase
                end
            end

            assign pulse[i] = pulse_q;
        end else begin : g_no_rpt
            assign pulse[i] = press_q;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed plus randomised stimulus for key_conditioner,
// compared every cycle against a window-based behavioural model.
module tb_key_conditioner;

    localparam int         N   = 4;
    localparam int         S   = 2;
    localparam int         D   = 4;
    localparam int         DLY = 10;
    localparam int         PER = 3;
    localparam logic [3:0] REN = 4'b0010;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] key_in;
    logic [3:0] held, press, released, pulse;

    key_conditioner #(
        .N_KEYS(N), .ACTIVE_LOW(1'b1), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .REPEAT_EN(REN), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) dut (
        .Clk(Clk), .Reset(Reset), .key_in(key_in),
        .held(held), .press(press), .released(released), .pulse(pulse)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Model state: pipeline of raw samples, window of debouncer inputs, expectations
    bit         raw_q  [N][$];
    bit         seen_q [N][$];
    logic [3:0] m_held, e_press, e_rel, e_pulse;
    int         edge_n = 0;
    int         press_edge [N];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            raw_q[ch].delete();
            repeat (S) raw_q[ch].push_back(1'b0);
            seen_q[ch].delete();
        end
        m_held  = '0;
        e_press = '0;
        e_rel   = '0;
        e_pulse = '0;
    endtask

    // One clock edge of the reference: the level seen by the debouncer lags the pin
    // by S edges; the accepted level flips once the last D seen levels all disagree
    task automatic model_edge();
        edge_n++;
        if (Reset) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < N; ch++) begin
            bit seen;
            bit all_diff;
            int d;
            raw_q[ch].push_back(!key_in[ch]);
            seen = raw_q[ch].pop_front();
            seen_q[ch].push_back(seen);
            if (seen_q[ch].size() > D) void'(seen_q[ch].pop_front());
            all_diff = (seen_q[ch].size() == D);
            for (int k = 0; k < seen_q[ch].size(); k++)
                if (seen_q[ch][k] == m_held[ch]) all_diff = 1'b0;
            e_press[ch] = all_diff && !m_held[ch];
            e_rel[ch]   = all_diff && m_held[ch];
            if (all_diff) begin
                m_held[ch] = !m_held[ch];
                if (m_held[ch]) press_edge[ch] = edge_n;
            end
            d = edge_n - press_edge[ch];
            if (REN[ch])
                e_pulse[ch] = m_held[ch] && (d == 0 || d == DLY || (d > DLY && (d - DLY) % PER == 0));
            else
                e_pulse[ch] = e_press[ch];
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        chk("held", held, m_held);
        chk("press", press, e_press);
        chk("release", released, e_rel);
        chk("pulse", pulse, e_pulse);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    // Step until press (or release) appears on a channel and check the edge count
    task automatic wait_event(string tag, int ch, bit want_rel, int exp_steps);
        int  n   = 0;
        bit  hit = 1'b0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            step();
            if ((want_rel ? released[ch] : press[ch]) === 1'b1) begin
                hit = 1'b1;
                n   = k;
            end
        end
        chk(tag, n, exp_steps);
    endtask

    task automatic async_reset_check(string tag);
        Reset = 1'b1;
        #1;
        chk(tag, {held, press, released, pulse}, 16'h0000);
        model_reset();
    endtask

    initial begin
        int p0, p1;
        Reset  = 1'b0;
        key_in = 4'hF;
        model_reset();
        #1 Reset = 1'b1;
        @(negedge Clk);

        // 1: reset with all keys idle, then 20 quiet cycles
        run(3);
        chk("t1_reset", {held, press, released, pulse}, 16'h0000);
        Reset = 1'b0;
        run(20);

        // 2: single press and release latency
        key_in = 4'b1110;
        wait_event("t2_press_lat", 0, 1'b0, 6);
        run(3);
        key_in = 4'b1111;
        wait_event("t2_rel_lat", 0, 1'b1, 6);
        run(4);

        // 3: short bounces are ignored, then a real press
        repeat (5) begin
            key_in = 4'b1110; run(3);
            key_in = 4'b1111; run(3);
        end
        chk("t3_no_held", held, 4'b0000);
        key_in = 4'b1110;
        wait_event("t3_press_lat", 0, 1'b0, 6);
        run(2);

        // 4: two keys together, only key1 repeats
        key_in = 4'b1111;
        run(10);
        key_in = 4'b1100;
        p0 = 0; p1 = 0;
        for (int k = 0; k < 37; k++) begin
            step();
            p0 += int'(pulse[0]);
            p1 += int'(pulse[1]);
        end
        chk("t4_pulse0_cnt", p0, 1);
        chk("t4_pulse1_cnt", p1, 9);
        key_in = 4'b1110;
        wait_event("t4_rel1_lat", 1, 1'b1, 6);
        chk("t4_no_pulse_at_rel", pulse[1], 1'b0);
        p1 = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            p1 += int'(pulse[1]);
        end
        chk("t4_no_pulse_after", p1, 0);

        // 5: press on one channel and release on another in the same cycle
        key_in = 4'b1011;
        run(15);
        key_in = 4'b1110;
        wait_event("t5_press0_lat", 0, 1'b0, 6);
        chk("t5_rel2_same_edge", released[2], 1'b1);
        chk("t5_others", {held[3], held[1]}, 2'b00);
        run(3);

        // 6: asynchronous reset mid-repeat and mid-debounce
        key_in = 4'b1100;
        run(20);
        key_in = 4'b0100;
        run(4);
        async_reset_check("t6_async");
        run(3);
        Reset = 1'b0;
        wait_event("t6_press1_lat", 1, 1'b0, 6);
        chk("t6_no_rel1", released[1], 1'b0);
        run(5);

        // Randomised key activity, with one asynchronous reset in the middle
        for (int s = 0; s < 60; s++) begin
            key_in = 4'($urandom);
            run($urandom_range(1, 24));
            if (s == 30) begin
                async_reset_check("rnd_async");
                run(2);
                Reset = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
